// File: rtl/mips8_host_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mips8_host_pkg
//  Purpose  : Shared constants for the MIPS8 Wishbone host port: register
//             offsets, CTRL/STATUS bit positions, handshake FSM states and
//             the register-select decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package mips8_host_pkg;

    // Register offsets within the 512-byte window (adr[8:0])
    localparam logic [8:0] OFF_CTRL   = 9'h000;
    localparam logic [8:0] OFF_STATUS = 9'h004;
    localparam logic [8:0] OFF_FIFO   = 9'h008;

    // CTRL bit positions
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_SOFT_RST = 1;

    // STATUS bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_HALTED  = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // Handshake FSM states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    // Which register an in-window offset selects
    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_FIFO,
        REG_PMEM,
        REG_NONE
    } reg_sel_e;

    // The upper half of the window (0x100-0x1FF) is program memory
    function automatic reg_sel_e decode_offset(input logic [8:0] off);
        if (off[8])                 return REG_PMEM;
        else if (off == OFF_CTRL)   return REG_CTRL;
        else if (off == OFF_STATUS) return REG_STATUS;
        else if (off == OFF_FIFO)   return REG_FIFO;
        else                        return REG_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mips8_host_port_if.sv
`default_nettype none
// ============================================================================
//  Interface : wb_mips8_host_port_if
//  Purpose   : Wishbone classic slave-side bundle between the management
//              core and the MIPS8 host port.
//  Revision  : 1.0  initial release
// ============================================================================
interface wb_mips8_host_port_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/mips8_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mips8_out_fifo
//  Purpose  : Synchronous core->host byte FIFO with occupancy count.
//             A push while full (and not popping) is dropped and flagged
//             on drop_o for one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mips8_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic w_do_push, w_do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-when-full is accepted then
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign drop_o    = push_i & ~w_do_push;

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
            else if (!w_do_push && w_do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; only the pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/wb_mips8_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mips8_host_port
//  Purpose  : Wishbone classic responder letting the management core load
//             MIPS8 program memory, control the core's run/reset, and drain
//             the core's output FIFO. Also serves the core's fetch port.
//  Revision : 1.0  initial release
// ============================================================================
module wb_mips8_host_port
    import mips8_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          MEM_AW     = 6,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_mips8_host_port_if.slave  wbs,
    output logic                 core_rst_no,
    input  logic [7:0]           core_imem_addr,
    output logic [7:0]           core_imem_data,
    input  logic                 core_out_valid,
    input  logic [7:0]           core_out_data,
    input  logic                 core_halted
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Registered state
    logic [0:0]  state_q, state_d;
    logic [31:0] dat_q,   dat_d;
    logic        run_q,   run_d;
    logic        soft_q,  soft_d;
    logic        ovf_q,   ovf_d;
    logic [7:0]  imem_byte_q;
    logic [31:0] pmem_q [2**MEM_AW];

    // Combinational
    logic           w_in_win, w_req, w_pop, w_pmem_we;
    reg_sel_e       w_sel;
    logic [31:0]    w_rd_data, w_status, w_core_word;
    logic [7:0]     w_fifo_data;
    logic           w_fifo_empty, w_fifo_full, w_fifo_drop;
    logic [CW-1:0]  w_fifo_count;
    logic [MEM_AW-1:0] w_host_idx;

    mips8_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (core_out_valid),
        .data_i  (core_out_data),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full),
        .count_o (w_fifo_count),
        .drop_o  (w_fifo_drop)
    );

    assign w_in_win   = (wbs.wbs_adr_i[31:9] == BASE_ADDR[31:9]);
    assign w_sel      = decode_offset(wbs.wbs_adr_i[8:0]);
    assign w_req      = (state_q == S_IDLE) & wbs.wbs_cyc_i & wbs.wbs_stb_i & w_in_win;
    assign w_host_idx = wbs.wbs_adr_i[MEM_AW+1:2];

    assign w_status = {16'h0000, 8'(w_fifo_count), 4'h0,
                       ovf_q, core_halted, w_fifo_full, w_fifo_empty};

    assign wbs.wbs_ack_o = (state_q == S_ACK);
    assign wbs.wbs_dat_o = dat_q;

    // The soft-reset pulse masks the core reset for exactly one cycle
    assign core_rst_no    = wb_rst_ni & run_q & ~soft_q;
    assign core_imem_data = imem_byte_q;
    assign w_core_word    = pmem_q[core_imem_addr[MEM_AW+1:2]];

    // Read-data mux for the addressed register
    always_comb begin
        w_rd_data = 32'h0;
        case (w_sel)
            REG_CTRL:   w_rd_data = {31'h0, run_q};
            REG_STATUS: w_rd_data = w_status;
            REG_FIFO:   w_rd_data = w_fifo_empty ? 32'h0 : {24'h0, w_fifo_data};
            REG_PMEM:   w_rd_data = pmem_q[w_host_idx];
            default:    w_rd_data = 32'h0;
        endcase
    end

    // Handshake FSM and register side effects, all committed on the request edge
    always_comb begin
        state_d   = state_q;
        dat_d     = dat_q;
        run_d     = run_q;
        soft_d    = 1'b0;
        ovf_d     = ovf_q | w_fifo_drop;
        w_pop     = 1'b0;
        w_pmem_we = 1'b0;
        if (state_q == S_IDLE) begin
            if (w_req) begin
                state_d = S_ACK;
                if (wbs.wbs_we_i) begin
                    case (w_sel)
                        REG_CTRL: begin
                            if (wbs.wbs_sel_i[0]) begin
                                run_d  = wbs.wbs_dat_i[CTRL_RUN];
                                soft_d = wbs.wbs_dat_i[CTRL_SOFT_RST];
                            end
                        end
                        // A drop in the same cycle wins over the clear
                        REG_STATUS: ovf_d     = w_fifo_drop;
                        REG_PMEM:   w_pmem_we = 1'b1;
                        default:    ;
                    endcase
                end else begin
                    dat_d = w_rd_data;
                    w_pop = (w_sel == REG_FIFO);
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // Control/status registers with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            dat_q   <= 32'h0;
            run_q   <= 1'b0;
            soft_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            run_q   <= run_d;
            soft_q  <= soft_d;
            ovf_q   <= ovf_d;
        end
    end

    // Host byte-lane writes into program memory; contents survive reset
    always_ff @(posedge wb_clk_i) begin
        if (w_pmem_we && wb_rst_ni) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs.wbs_sel_i[b]) pmem_q[w_host_idx][8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
            end
        end
    end

    // Core fetch port: registered byte read, sees pre-write data on a collision
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) imem_byte_q <= 8'h00;
        else            imem_byte_q <= w_core_word[{core_imem_addr[1:0], 3'b000} +: 8];
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mips8_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mips8_host_port
//  Purpose  : Directed self-checking bench for wb_mips8_host_port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_mips8_host_port;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_FIFO   = 32'h3000_0008;
    localparam logic [31:0] A_PMEM0  = 32'h3000_0100;
    localparam logic [31:0] A_PMEM1  = 32'h3000_0104;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       core_rst_no;
    logic [7:0] core_imem_addr;
    logic [7:0] core_imem_data;
    logic       core_out_valid;
    logic [7:0] core_out_data;
    logic       core_halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_mips8_host_port_if bus ();

    wb_mips8_host_port #(
        .BASE_ADDR  (32'h3000_0000),
        .MEM_AW     (6),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .wbs            (bus),
        .core_rst_no    (core_rst_no),
        .core_imem_addr (core_imem_addr),
        .core_imem_data (core_imem_data),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .core_halted    (core_halted)
    );

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        rn_ack;
        logic        rn_nxt;
        logic [7:0]  im_ack;
        logic [7:0]  im_nxt;
    } xfer_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One bus transfer, called #1 after a rising edge; waits at most max_cyc edges for ack
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int max_cyc, output xfer_t r);
        r.rdata = 32'h0; r.lat = 0; r.rn_ack = 1'b0; r.rn_nxt = 1'b0;
        r.im_ack = 8'h0; r.im_nxt = 8'h0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                r.lat = i; r.rdata = bus.wbs_dat_o;
                r.rn_ack = core_rst_no; r.im_ack = core_imem_data;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(posedge clk); #1;
        r.rn_nxt = core_rst_no; r.im_nxt = core_imem_data;
        if (r.lat != 0) check("ack_one_cycle", {31'h0, bus.wbs_ack_o}, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output xfer_t r);
        xfer(1'b1, adr, dat, sel, 4, r);
        check({tag, "_lat"}, r.lat, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        xfer_t r;
        xfer(1'b0, adr, 32'h0, 4'hF, 4, r);
        check({tag, "_lat"}, r.lat, 32'd1);
        check(tag, r.rdata, exp);
    endtask

    initial begin
        xfer_t r;
        rst_n = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        core_imem_addr = 8'h00; core_out_valid = 1'b0; core_out_data = 8'h00; core_halted = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   {31'h0, bus.wbs_ack_o}, 32'h0);
        check("rst_dat",   bus.wbs_dat_o, 32'h0);
        check("rst_corern", {31'h0, core_rst_no}, 32'h0);
        check("rst_imem",  {24'h0, core_imem_data}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd("status_rst", A_STATUS, 32'h0000_0001);
        rd("ctrl_rst",   A_CTRL,   32'h0000_0000);

        // 1: byte-lane write into program memory
        wr("pmem_clr", A_PMEM0, 32'h0000_0000, 4'hF, r);
        wr("pmem_sel", A_PMEM0, 32'hDEAD_BEEF, 4'b0011, r);
        rd("pmem_sel_rd", A_PMEM0, 32'h0000_BEEF);

        // 2: program load, run, core fetch
        wr("pmem_w0", A_PMEM0, 32'h4433_2211, 4'hF, r);
        core_imem_addr = 8'd2;
        @(posedge clk); #1;
        check("imem_byte2", {24'h0, core_imem_data}, 32'h33);
        check("corern_before_run", {31'h0, core_rst_no}, 32'h0);
        wr("ctrl_run", A_CTRL, 32'h1, 4'hF, r);
        check("corern_at_ack", {31'h0, r.rn_ack}, 32'h1);
        // Collision: core reads the word being written and must see old data
        wr("pmem_w0b", A_PMEM0, 32'hAABB_CCDD, 4'hF, r);
        check("imem_collide_old", {24'h0, r.im_ack}, 32'h33);
        check("imem_collide_new", {24'h0, r.im_nxt}, 32'hBB);

        // 3: FIFO fill past full, drain, underflow
        for (int i = 0; i < 5; i++) begin
            core_out_valid = 1'b1; core_out_data = 8'(8'h10 + i);
            @(posedge clk); #1;
        end
        core_out_valid = 1'b0;
        rd("status_full_ovf", A_STATUS, 32'h0000_040A);
        for (int i = 0; i < 4; i++) rd("fifo_pop", A_FIFO, 32'(8'h10 + i));
        rd("fifo_pop_empty", A_FIFO, 32'h0);
        rd("status_empty_ovf", A_STATUS, 32'h0000_0009);
        wr("status_clr", A_STATUS, 32'h0, 4'hF, r);
        core_halted = 1'b1;
        rd("status_halted", A_STATUS, 32'h0000_0005);
        core_halted = 1'b0;

        // Push and pop in the same cycle while full
        for (int i = 0; i < 4; i++) begin
            core_out_valid = 1'b1; core_out_data = 8'(8'h20 + i);
            @(posedge clk); #1;
        end
        core_out_valid = 1'b1; core_out_data = 8'h24;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = A_FIFO; bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        core_out_valid = 1'b0;
        check("pp_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        check("pp_data", bus.wbs_dat_o, 32'h20);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        rd("status_pp", A_STATUS, 32'h0000_0402);
        for (int i = 1; i < 5; i++) rd("fifo_pp_pop", A_FIFO, 32'(8'h20 + i));
        rd("status_drained", A_STATUS, 32'h0000_0001);

        // 4: out-of-window is never acked, unmapped in-window reads 0
        xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 8, r);
        check("oow_no_ack", r.lat, 32'd0);
        wr("unmapped_wr", 32'h3000_000C, 32'hFFFF_FFFF, 4'hF, r);
        rd("unmapped_rd", 32'h3000_000C, 32'h0);

        // 5: soft reset pulse while running
        check("corern_running", {31'h0, core_rst_no}, 32'h1);
        wr("ctrl_soft", A_CTRL, 32'h3, 4'hF, r);
        check("soft_low", {31'h0, r.rn_ack}, 32'h0);
        check("soft_release", {31'h0, r.rn_nxt}, 32'h1);
        check("soft_stays_high", {31'h0, core_rst_no}, 32'h1);
        rd("ctrl_readback", A_CTRL, 32'h1);

        // 6: reset during a request cycle aborts it
        wr("pmem_w1", A_PMEM1, 32'h1234_5678, 4'hF, r);
        rd("pmem_w1_rd", A_PMEM1, 32'h1234_5678);
        core_out_valid = 1'b1; core_out_data = 8'h55;
        @(posedge clk); #1;
        core_out_valid = 1'b0;
        rst_n = 1'b0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = A_PMEM1; bus.wbs_dat_i = 32'hFFFF_FFFF; bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("rr_ack",    {31'h0, bus.wbs_ack_o}, 32'h0);
        check("rr_dat",    bus.wbs_dat_o, 32'h0);
        check("rr_corern", {31'h0, core_rst_no}, 32'h0);
        check("rr_imem",   {24'h0, core_imem_data}, 32'h0);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rr_ack_after", {31'h0, bus.wbs_ack_o}, 32'h0);
        rd("rr_pmem_kept", A_PMEM1, 32'h1234_5678);
        rd("rr_status", A_STATUS, 32'h0000_0001);
        rd("rr_ctrl", A_CTRL, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
